hwpe_stream_tcdm_rr_arbiter: RTL

Shares one TCDM master port among NB_IN TCDM requesters (streamers, accelerator ports) using round-robin arbitration. Routes read responses back to the issuing requester via an in-order ID FIFO, so memory read latency of one or more cycles is supported. Sits between HWPE streamers and the cluster TCDM interconnect.

---
 rtl/hwpe_stream_tcdm_rr_arbiter_pkg.sv | 16 +
 rtl/hwpe_stream_tcdm_arb_id_fifo.sv | 82 ++++++++
 rtl/hwpe_stream_tcdm_rr_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_package
// Purpose  : Shared TCDM width constants for the HWPE streamer/arbiter slice.
// Contents : TCDM_ADDR_WIDTH, TCDM_DATA_WIDTH, TCDM_BE_WIDTH, STALL_CNT_WIDTH
// Revision : 1.0 - initial release
// ============================================================================
package hwpe_stream_package;

    localparam int unsigned TCDM_ADDR_WIDTH = 32;
    localparam int unsigned TCDM_DATA_WIDTH = 32;
    localparam int unsigned TCDM_BE_WIDTH   = 4;
    localparam int unsigned STALL_CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_arb_id_fifo
// Purpose  : In-order FIFO holding the requester ID of every read in flight.
//            Push and pop in the same cycle leave the occupancy unchanged;
//            full/empty come from the registered count only.
// Ports    : clk_i, rst_ni (sync, active-low), flush_i (sync clear),
//            push_i/data_i (enqueue), pop_i (dequeue), head_o (oldest ID),
//            full_o, empty_o
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_arb_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = p + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: head_o is only consumed while non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_rr_arbiter
// Purpose  : Round-robin arbiter sharing one TCDM master port among NB_IN
//            requesters. Read responses are routed back in order through an
//            ID FIFO, so any read latency of one cycle or more is supported.
// Ports    : clk_i, rst_ni (sync, active-low), clear_i (sync soft clear)
//            in_*  : NB_IN requester side (req/gnt/add/wen/be/data, r_data/r_valid)
//            out_* : shared TCDM master side
//            stall_cnt_clr_i, stall_cnt_o : only with HWPE_TCDM_ARB_STALL_CNT_EN
// Options  : `define HWPE_TCDM_ARB_STALL_CNT_EN adds per-requester 16-bit
//            saturating stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_rr_arbiter
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = $clog2(NB_IN)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
    input  logic                              stall_cnt_clr_i,
    output logic [NB_IN*STALL_CNT_WIDTH-1:0]  stall_cnt_o,
`endif
    input  logic [NB_IN-1:0]                  in_req_i,
    output logic [NB_IN-1:0]                  in_gnt_o,
    input  logic [NB_IN*TCDM_ADDR_WIDTH-1:0]  in_add_i,
    input  logic [NB_IN-1:0]                  in_wen_i,
    input  logic [NB_IN*TCDM_BE_WIDTH-1:0]    in_be_i,
    input  logic [NB_IN*TCDM_DATA_WIDTH-1:0]  in_data_i,
    output logic [NB_IN*TCDM_DATA_WIDTH-1:0]  in_r_data_o,
    output logic [NB_IN-1:0]                  in_r_valid_o,
    output logic                              out_req_o,
    input  logic                              out_gnt_i,
    output logic [TCDM_ADDR_WIDTH-1:0]        out_add_o,
    output logic                              out_wen_o,
    output logic [TCDM_BE_WIDTH-1:0]          out_be_o,
    output logic [TCDM_DATA_WIDTH-1:0]        out_data_o,
    input  logic [TCDM_DATA_WIDTH-1:0]        out_r_data_i,
    input  logic                              out_r_valid_i
);

    logic [ID_WIDTH-1:0]        r_ptr;
    logic [NB_IN-1:0]           w_eligible;
    logic [ID_WIDTH-1:0]        w_winner;
    logic                       w_any;
    logic                       w_handshake;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [ID_WIDTH-1:0]        w_head;

    logic [TCDM_ADDR_WIDTH-1:0] w_add  [NB_IN];
    logic [TCDM_BE_WIDTH-1:0]   w_be   [NB_IN];
    logic [TCDM_DATA_WIDTH-1:0] w_data [NB_IN];

    // (base + off) mod NB_IN for base < NB_IN and off <= NB_IN-1.
    function automatic logic [ID_WIDTH-1:0] f_wrap_add(
        input logic [ID_WIDTH-1:0] base,
        input int unsigned         off
    );
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NB_IN) begin
            sum = sum - NB_IN;
        end
        return ID_WIDTH'(sum);
    endfunction

    // Slice the flat requester buses; reads may only compete while the ID
    // FIFO has room, writes never wait on it.
    for (genvar g = 0; g < NB_IN; g++) begin : g_unpack
        assign w_add[g]      = in_add_i[g*TCDM_ADDR_WIDTH +: TCDM_ADDR_WIDTH];
        assign w_be[g]       = in_be_i[g*TCDM_BE_WIDTH +: TCDM_BE_WIDTH];
        assign w_data[g]     = in_data_i[g*TCDM_DATA_WIDTH +: TCDM_DATA_WIDTH];
        assign w_eligible[g] = in_req_i[g] & (~in_wen_i[g] | ~w_fifo_full);
    end

    // First eligible requester scanning from the round-robin pointer.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        for (int unsigned k = 0; k < NB_IN; k++) begin
            if (!w_any && w_eligible[f_wrap_add(r_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = f_wrap_add(r_ptr, k);
            end
        end
    end

    // With nobody eligible w_winner is 0, so requester 0's fields show.
    assign out_req_o  = w_any;
    assign out_add_o  = w_add[w_winner];
    assign out_wen_o  = in_wen_i[w_winner];
    assign out_be_o   = w_be[w_winner];
    assign out_data_o = w_data[w_winner];

    always_comb begin
        in_gnt_o = '0;
        if (w_any) begin
            in_gnt_o[w_winner] = out_gnt_i;
        end
    end

    assign w_handshake = w_any & out_gnt_i;
    assign w_push      = w_handshake & out_wen_o;
    assign w_pop       = out_r_valid_i & ~w_fifo_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_ptr <= '0;
        end else if (w_handshake) begin
            r_ptr <= f_wrap_add(w_winner, 1);
        end
    end

    hwpe_stream_tcdm_arb_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (w_push),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // A response with no read in flight is dropped rather than routed.
    always_comb begin
        in_r_valid_o = '0;
        if (w_pop) begin
            in_r_valid_o[w_head] = 1'b1;
        end
    end

    assign in_r_data_o = {NB_IN{out_r_data_i}};

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && out_r_valid_i && w_fifo_empty) begin
            a_spurious_dropped : assert (in_r_valid_o == '0);
        end
    end
`endif

`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
    // Counts cycles a requester waits; saturates, clear beats increment.
    for (genvar g = 0; g < NB_IN; g++) begin : g_stall_cnt
        logic [STALL_CNT_WIDTH-1:0] r_cnt;
        always_ff @(posedge clk_i) begin
            if (!rst_ni || clear_i || stall_cnt_clr_i) begin
                r_cnt <= '0;
            end else if (in_req_i[g] && !in_gnt_o[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + STALL_CNT_WIDTH'(1);
            end
        end
        assign stall_cnt_o[g*STALL_CNT_WIDTH +: STALL_CNT_WIDTH] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
